// File: rtl/riscv_mem_pkg.sv
// Shared types for the RISC-V instruction/data memory arbiter:
// port owner, arbiter FSM state and the latency-counter width.
package riscv_mem_pkg;

    localparam int unsigned LAT_W = 4;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/riscv_arb_pick.sv
// Combinational winner select between fetch (I) and load/store (D).
// ARB_ROUND_ROBIN_EN: alternate on joint requests using a last-owner pointer; else D > I.
module riscv_arb_pick
    import riscv_mem_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   take,
    output logic   any_c,
    output owner_t win_c
);

    assign any_c = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last;

    // Pointer records the port granted most recently; reset favours I on the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= OWN_D;
        end else if (take) begin
            last <= win_c;
        end
    end

    always_comb begin
        win_c = OWN_D;
        if (i_req && d_req) begin
            win_c = (last == OWN_D) ? OWN_I : OWN_D;
        end else if (i_req) begin
            win_c = OWN_I;
        end
    end
`else
    logic unused_rr;

    assign unused_rr = ^{clock, reset, take};

    always_comb begin
        win_c = OWN_D;
        if (i_req && !d_req) begin
            win_c = OWN_I;
        end
    end
`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Serialises fetch (I) and load/store (D) accesses onto one fixed-latency memory.
// Optional ARB_ROUND_ROBIN_EN swaps fixed D>I priority for round-robin on joint requests.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    arb_state_t       state;
    owner_t           owner;
    logic             cap_we;
    logic [LAT_W-1:0] cnt;
    logic             any_c;
    logic             take_c;
    owner_t           win_c;

    assign take_c = (state == IDLE) && any_c;

    riscv_arb_pick u_pick (
        .clock (clock),
        .reset (reset),
        .i_req (i_req),
        .d_req (d_req),
        .take  (take_c),
        .any_c (any_c),
        .win_c (win_c)
    );

    // Access sequencer: winner is captured straight into the memory-side registers so
    // gnt and mem_en appear together in the ISSUE cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_I;
            cap_we    <= 1'b0;
            cnt       <= '0;
            i_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            mem_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_c) begin
                        owner  <= win_c;
                        mem_en <= 1'b1;
                        state  <= ISSUE;
                        if (win_c == OWN_D) begin
                            d_gnt     <= 1'b1;
                            cap_we    <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            i_gnt    <= 1'b1;
                            cap_we   <= 1'b0;
                            mem_we   <= 1'b0;
                            mem_addr <= i_addr;
                        end
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    cnt    <= LAT_LOAD;
                    state  <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - LAT_ONE;
                    // Count of 1 marks the cycle the memory presents read data.
                    if (cnt == LAT_ONE) begin
                        state <= IDLE;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            if (!cap_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: three instances (MEM_LAT 1, 4, 15), a latency-accurate memory
// per instance and a cycle-timeline reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;

    localparam int NU = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 15);
    endfunction

    function automatic logic [63:0] init_word(input int k, input int i);
        if (i == 2) return 64'hDEAD;
        return {32'(k + 1), 32'(i) * 32'h9E37_79B9};
    endfunction

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req     [NU];
    logic [63:0] i_addr    [NU];
    logic        i_gnt     [NU];
    logic        i_rvalid  [NU];
    logic [63:0] i_rdata   [NU];
    logic        d_req     [NU];
    logic        d_we      [NU];
    logic [63:0] d_addr    [NU];
    logic [63:0] d_wdata   [NU];
    logic        d_gnt     [NU];
    logic        d_rvalid  [NU];
    logic [63:0] d_rdata   [NU];
    logic        mem_en    [NU];
    logic        mem_we    [NU];
    logic [63:0] mem_addr  [NU];
    logic [63:0] mem_wdata [NU];
    logic [63:0] mem_rdata [NU];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    for (genvar K = 0; K < NU; K++) begin : g_u
        localparam int L = lat_of(K);

        riscv_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(L)) dut (
            .clock     (clock),
            .reset     (reset),
            .i_req     (i_req[K]),
            .i_addr    (i_addr[K]),
            .i_gnt     (i_gnt[K]),
            .i_rvalid  (i_rvalid[K]),
            .i_rdata   (i_rdata[K]),
            .d_req     (d_req[K]),
            .d_we      (d_we[K]),
            .d_addr    (d_addr[K]),
            .d_wdata   (d_wdata[K]),
            .d_gnt     (d_gnt[K]),
            .d_rvalid  (d_rvalid[K]),
            .d_rdata   (d_rdata[K]),
            .mem_en    (mem_en[K]),
            .mem_we    (mem_we[K]),
            .mem_addr  (mem_addr[K]),
            .mem_wdata (mem_wdata[K]),
            .mem_rdata (mem_rdata[K])
        );

        // Memory: read data valid exactly L cycles after mem_en, random garbage otherwise.
        logic [63:0] envmem [64];
        logic [63:0] refmem [64];
        int          pend = 0;
        logic [63:0] pdata;

        initial begin
            for (int i = 0; i < 64; i++) begin
                envmem[i] = init_word(K, i);
                refmem[i] = init_word(K, i);
            end
        end

        always @(posedge clock) begin
            if (mem_en[K]) begin
                if (mem_we[K]) envmem[mem_addr[K][8:3]] = mem_wdata[K];
                pdata = envmem[mem_addr[K][8:3]];
                if (L == 1) begin
                    mem_rdata[K] <= pdata;
                    pend = 0;
                end else begin
                    mem_rdata[K] <= {$urandom, $urandom};
                    pend = L - 1;
                end
            end else if (pend > 0) begin
                mem_rdata[K] <= (pend == 1) ? pdata : {$urandom, $urandom};
                pend = pend - 1;
            end else begin
                mem_rdata[K] <= {$urandom, $urandom};
            end
        end

        // Reference: an access sampled in cycle c grants in c+1, completes in c+2+L,
        // and the arbiter may sample again from cycle c+2+L.
        int          cyc = 0;
        int          gnt_at = -1;
        int          rv_at = -1;
        int          free_at = 0;
        bit          m_d;
        bit          m_we;
        bit          last_d = 1'b1;
        logic [63:0] m_addr, m_wdata, m_rdata;
        logic [63:0] hold_i = '0;
        logic [63:0] hold_d = '0;
        logic [5:0]  exp_p, got_p;

        always @(negedge clock) begin
            got_p = {i_gnt[K], d_gnt[K], i_rvalid[K], d_rvalid[K], mem_en[K], mem_en[K] & mem_we[K]};
            if (reset) begin
                gnt_at = -1; rv_at = -1; free_at = 0; last_d = 1'b1;
                hold_i = '0; hold_d = '0;
                check_eq($sformatf("u%0d_reset_pulses", K), 64'(got_p), 64'd0);
                check_eq($sformatf("u%0d_reset_mem_addr", K), mem_addr[K], 64'd0);
                check_eq($sformatf("u%0d_reset_mem_wdata", K), mem_wdata[K], 64'd0);
                check_eq($sformatf("u%0d_reset_i_rdata", K), i_rdata[K], 64'd0);
                check_eq($sformatf("u%0d_reset_d_rdata", K), d_rdata[K], 64'd0);
            end else begin
                if (rv_at == cyc) begin
                    if (!m_d) hold_i = m_rdata;
                    else if (!m_we) hold_d = m_rdata;
                end
                exp_p = {(gnt_at == cyc) && !m_d, (gnt_at == cyc) && m_d,
                         (rv_at == cyc) && !m_d, (rv_at == cyc) && m_d,
                         (gnt_at == cyc), (gnt_at == cyc) && m_we};
                check_eq($sformatf("u%0d_pulses@%0d", K, cyc), 64'(got_p), 64'(exp_p));
                if (gnt_at == cyc) begin
                    check_eq($sformatf("u%0d_mem_addr", K), mem_addr[K], m_addr);
                    if (m_we) check_eq($sformatf("u%0d_mem_wdata", K), mem_wdata[K], m_wdata);
                end
                check_eq($sformatf("u%0d_i_rdata@%0d", K, cyc), i_rdata[K], hold_i);
                check_eq($sformatf("u%0d_d_rdata@%0d", K, cyc), d_rdata[K], hold_d);
                if (cyc >= free_at && (i_req[K] || d_req[K])) begin
`ifdef ARB_ROUND_ROBIN_EN
                    m_d = d_req[K] && (!i_req[K] || !last_d);
`else
                    m_d = d_req[K];
`endif
                    last_d  = m_d;
                    m_addr  = m_d ? d_addr[K] : i_addr[K];
                    m_we    = m_d && d_we[K];
                    m_wdata = d_wdata[K];
                    if (m_we) refmem[m_addr[8:3]] = m_wdata;
                    else m_rdata = refmem[m_addr[8:3]];
                    gnt_at  = cyc + 1;
                    rv_at   = cyc + 2 + L;
                    free_at = rv_at;
                end
            end
            cyc++;
        end
    end

    // One request/complete handshake on unit k; call and return at posedge+1.
    task automatic access(input int k, input bit is_d, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata, output int g_lat);
        bit seen;
        int g2r;
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = addr;
        end
        seen  = 1'b0;
        g_lat = 0;
        while (g_lat < 200 && !seen) begin
            @(posedge clock); #1;
            g_lat++;
            seen = is_d ? d_gnt[k] : i_gnt[k];
        end
        check_eq($sformatf("u%0d_%s_gnt_seen", k, is_d ? "d" : "i"), 64'(seen), 64'd1);
        if (is_d) d_req[k] = 1'b0;
        else i_req[k] = 1'b0;
        seen = 1'b0;
        g2r  = 0;
        while (g2r < 200 && !seen) begin
            @(posedge clock); #1;
            g2r++;
            seen = is_d ? d_rvalid[k] : i_rvalid[k];
        end
        check_eq($sformatf("u%0d_%s_gnt_to_rvalid", k, is_d ? "d" : "i"), 64'(g2r), 64'(lat_of(k) + 1));
        rdata = is_d ? d_rdata[k] : i_rdata[k];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, rd_i, rd_d;
        int          gl, gl_i, gl_d, cnt;
        bit          seen;
        reset = 1'b1;
        for (int k = 0; k < NU; k++) begin
            i_req[k] = 1'b0; i_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        access(0, 1'b0, 1'b0, 64'h10, 64'd0, rd, gl);
        check_eq("fetch_gnt_lat", 64'(gl), 64'd1);
        check_eq("fetch_rdata", rd, 64'hDEAD);

        access(0, 1'b1, 1'b1, 64'h40, 64'h1234, rd, gl);
        check_eq("store_gnt_lat", 64'(gl), 64'd1);
        check_eq("store_d_rdata_hold", rd, 64'd0);
        access(0, 1'b1, 1'b0, 64'h40, 64'd0, rd, gl);
        check_eq("load_after_store", rd, 64'h1234);

        for (int k = 0; k < NU; k++) begin
            access(k, 1'b0, 1'b0, 64'h10, 64'd0, rd, gl);
            check_eq($sformatf("sweep%0d_gnt_lat", k), 64'(gl), 64'd1);
            check_eq($sformatf("sweep%0d_rdata", k), rd, 64'hDEAD);
        end

        // Joint requests: first after an I access, second after a D access.
        for (int r = 0; r < 2; r++) begin
            if (r == 1) access(0, 1'b1, 1'b0, 64'h40, 64'd0, rd, gl);
            fork
                access(0, 1'b0, 1'b0, 64'h10, 64'd0, rd_i, gl_i);
                access(0, 1'b1, 1'b0, 64'h40, 64'd0, rd_d, gl_d);
            join
`ifdef ARB_ROUND_ROBIN_EN
            if (r == 1) begin
                check_eq("joint1_i_lat", 64'(gl_i), 64'd1);
                check_eq("joint1_d_lat", 64'(gl_d), 64'(lat_of(0) + 3));
            end else begin
                check_eq("joint0_d_lat", 64'(gl_d), 64'd1);
                check_eq("joint0_i_lat", 64'(gl_i), 64'(lat_of(0) + 3));
            end
`else
            check_eq($sformatf("joint%0d_d_lat", r), 64'(gl_d), 64'd1);
            check_eq($sformatf("joint%0d_i_lat", r), 64'(gl_i), 64'(lat_of(0) + 3));
`endif
            check_eq($sformatf("joint%0d_i_rdata", r), rd_i, 64'hDEAD);
            check_eq($sformatf("joint%0d_d_rdata", r), rd_d, 64'h1234);
        end

        fork
            access(1, 1'b1, 1'b0, 64'h40, 64'd0, rd, gl);
            begin
                repeat (2) begin @(posedge clock); #1; end
                i_req[1] = 1'b1; i_addr[1] = 64'h18;
                @(posedge clock); #1;
                i_req[1] = 1'b0;
            end
        join
        cnt = 0;
        repeat (30) begin
            @(posedge clock); #1;
            cnt += int'(i_gnt[1]) + int'(i_rvalid[1]);
        end
        check_eq("withdraw_no_i_pulse", 64'(cnt), 64'd0);

        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 64'h40;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clock); #1;
            seen = d_gnt[1];
        end
        check_eq("rst_test_gnt_seen", 64'(seen), 64'd1);
        d_req[1] = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        check_eq("rst_async_pulses", 64'({d_gnt[1], d_rvalid[1], mem_en[1], mem_we[1]}), 64'd0);
        check_eq("rst_async_mem_addr", mem_addr[1], 64'd0);
        check_eq("rst_async_d_rdata", d_rdata[1], 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(posedge clock); #1;
            cnt += int'(d_rvalid[1]) + int'(d_gnt[1]);
        end
        check_eq("rst_no_d_pulse", 64'(cnt), 64'd0);

        for (int k = 0; k < NU; k++) begin
            fork
                begin
                    logic [63:0] a, w, r;
                    int          g;
                    for (int j = 0; j < 10; j++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                        a = {$urandom, $urandom};
                        w = {$urandom, $urandom};
                        access(k, 1'b1, 1'($urandom_range(0, 1)), a, w, r, g);
                    end
                end
                begin
                    logic [63:0] a, r;
                    int          g;
                    for (int j = 0; j < 10; j++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                        a = {$urandom, $urandom};
                        access(k, 1'b0, 1'b0, a, 64'd0, r, g);
                    end
                end
            join
        end

        repeat (4) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
